// File: rtl/bram_tdp_model.sv
// True dual-port, single-clock block RAM model: per-lane writes, per-port write
// modes, optional output register with clock enable, and collision monitoring.
module bram_tdp_model #(
  parameter int LANES = 4,
  parameter int LANE_W = 9,
  parameter int ADDR_W = 10,
  parameter bit DO_REG_A = 1'b0,
  parameter bit DO_REG_B = 1'b0,
  parameter string WRITE_MODE_A = "WRITE_FIRST",
  parameter string WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [LANES*LANE_W-1:0] SRVAL_A = '0,
  parameter logic [LANES*LANE_W-1:0] SRVAL_B = '0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ENA,
  input  logic [LANES-1:0]          WEA,
  input  logic [ADDR_W-1:0]         ADDRA,
  input  logic [LANES*LANE_W-1:0]   DIA,
  input  logic                      SSRA,
  input  logic                      REGCEA,
  output logic [LANES*LANE_W-1:0]   DOA,
  input  logic                      ENB,
  input  logic [LANES-1:0]          WEB,
  input  logic [ADDR_W-1:0]         ADDRB,
  input  logic [LANES*LANE_W-1:0]   DIB,
  input  logic                      SSRB,
  input  logic                      REGCEB,
  output logic [LANES*LANE_W-1:0]   DOB,
  output logic                      COLLISION,
  output logic [15:0]               COLL_CNT
);

  localparam int DEPTH = 2**ADDR_W;
  // 0 = write-first, 1 = read-first, 2 = no-change, 3 = unrecognised
  localparam int MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? 0 :
                          (WRITE_MODE_A == "READ_FIRST")  ? 1 :
                          (WRITE_MODE_A == "NO_CHANGE")   ? 2 : 3;
  localparam int MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? 0 :
                          (WRITE_MODE_B == "READ_FIRST")  ? 1 :
                          (WRITE_MODE_B == "NO_CHANGE")   ? 2 : 3;

  if (MODE_A == 3) begin : g_bad_mode_a
    $fatal(1, "bram_tdp_model: illegal WRITE_MODE_A");
  end
  if (MODE_B == 3) begin : g_bad_mode_b
    $fatal(1, "bram_tdp_model: illegal WRITE_MODE_B");
  end

  logic wea_any;
  logic web_any;
  logic collide;
  logic collision_reg;
  logic [15:0] coll_cnt_reg;

  assign wea_any = |WEA;
  assign web_any = |WEB;
  assign collide = ENA && ENB && (ADDRA == ADDRB) && (wea_any || web_any);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [DEPTH];
      logic [LANE_W-1:0] old_a;
      logic [LANE_W-1:0] old_b;
      logic [LANE_W-1:0] di_a;
      logic [LANE_W-1:0] di_b;
      logic [LANE_W-1:0] latch_a_reg;
      logic [LANE_W-1:0] latch_b_reg;
      logic [LANE_W-1:0] out_a_reg;
      logic [LANE_W-1:0] out_b_reg;

      assign di_a  = DIA[gi*LANE_W +: LANE_W];
      assign di_b  = DIB[gi*LANE_W +: LANE_W];
      assign old_a = mem[ADDRA];
      assign old_b = mem[ADDRB];

      // Port B is written first so port A wins a same-lane, same-address clash.
      always_ff @(posedge CLK) begin
        if (!RST) begin
          if (ENB && WEB[gi]) mem[ADDRB] <= di_b;
          if (ENA && WEA[gi]) mem[ADDRA] <= di_a;
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          latch_a_reg <= '0;
        end else if (ENA) begin
          if (SSRA && !DO_REG_A)     latch_a_reg <= SRVAL_A[gi*LANE_W +: LANE_W];
          else if (MODE_A == 0)      latch_a_reg <= WEA[gi] ? di_a : old_a;
          else if (MODE_A == 1)      latch_a_reg <= old_a;
          else if (!wea_any)         latch_a_reg <= old_a;
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          latch_b_reg <= '0;
        end else if (ENB) begin
          if (SSRB && !DO_REG_B)     latch_b_reg <= SRVAL_B[gi*LANE_W +: LANE_W];
          else if (MODE_B == 0)      latch_b_reg <= WEB[gi] ? di_b : old_b;
          else if (MODE_B == 1)      latch_b_reg <= old_b;
          else if (!web_any)         latch_b_reg <= old_b;
        end
      end

      // Output register stage is gated only by its own clock enable.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          out_a_reg <= '0;
          out_b_reg <= '0;
        end else begin
          if (REGCEA) out_a_reg <= SSRA ? SRVAL_A[gi*LANE_W +: LANE_W] : latch_a_reg;
          if (REGCEB) out_b_reg <= SSRB ? SRVAL_B[gi*LANE_W +: LANE_W] : latch_b_reg;
        end
      end

      assign DOA[gi*LANE_W +: LANE_W] = DO_REG_A ? out_a_reg : latch_a_reg;
      assign DOB[gi*LANE_W +: LANE_W] = DO_REG_B ? out_b_reg : latch_b_reg;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      collision_reg <= 1'b0;
      coll_cnt_reg  <= '0;
    end else begin
      collision_reg <= collide;
      if (collide && (coll_cnt_reg != 16'hFFFF)) coll_cnt_reg <= coll_cnt_reg + 16'd1;
    end
  end

  assign COLLISION = collision_reg;
  assign COLL_CNT  = coll_cnt_reg;

endmodule

// File: tb/tb_bram_tdp_model.sv
// Bench for bram_tdp_model: three configurations share one stimulus stream and are
// checked against directed vectors, hand sequences and a word-level reference model.
module tb_bram_tdp_model;

  logic clk = 1'b0;
  logic rst;
  logic ena, enb, ssra, ssrb, regcea, regceb;
  logic [3:0] wea, web;
  logic [9:0] addra, addrb;
  logic [35:0] dia, dib;
  logic [35:0] doa [3];
  logic [35:0] dob [3];
  logic coll [3];
  logic [15:0] cnt [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // u0: write-first both ports, u1: read-first A / no-change B, u2: registered outputs
  bram_tdp_model #(.SRVAL_A(36'h1_5A5A_5A5A), .SRVAL_B(36'h0_0F0F_0F0F)) u0 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .SSRA(ssra), .REGCEA(regcea), .DOA(doa[0]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .SSRB(ssrb), .REGCEB(regceb), .DOB(dob[0]),
    .COLLISION(coll[0]), .COLL_CNT(cnt[0]));

  bram_tdp_model #(.WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
                   .SRVAL_A(36'h0_1234_0000), .SRVAL_B(36'h1_0000_0001)) u1 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .SSRA(ssra), .REGCEA(regcea), .DOA(doa[1]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .SSRB(ssrb), .REGCEB(regceb), .DOB(dob[1]),
    .COLLISION(coll[1]), .COLL_CNT(cnt[1]));

  bram_tdp_model #(.DO_REG_A(1'b1), .DO_REG_B(1'b1),
                   .SRVAL_A(36'h0_0000_0123), .SRVAL_B(36'h0_0000_0ABC)) u2 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .SSRA(ssra), .REGCEA(regcea), .DOA(doa[2]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .SSRB(ssrb), .REGCEB(regceb), .DOB(dob[2]),
    .COLLISION(coll[2]), .COLL_CNT(cnt[2]));

  // Reference model: word-level memory plus per-configuration read state.
  int mode_c [3][2];
  bit doreg_c [3][2];
  logic [35:0] srval_c [3][2];
  logic [35:0] mem_m [1024];
  logic [35:0] latch_m [3][2];
  logic [35:0] out_m [3][2];
  bit coll_m;
  int cnt_m;

  function automatic logic [35:0] lane_mask(input logic [3:0] we);
    logic [35:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (we[i]) m[i*9 +: 9] = 9'h1FF;
    return m;
  endfunction

  function automatic logic [35:0] exp_do(input int d, input int p);
    return doreg_c[d][p] ? out_m[d][p] : latch_m[d][p];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 2; p++) begin
        latch_m[d][p] = '0;
        out_m[d][p] = '0;
      end
    coll_m = 1'b0;
    cnt_m = 0;
  endtask

  task automatic model_edge();
    logic [35:0] old [2];
    logic [35:0] di [2];
    logic [35:0] m [2];
    logic [3:0] we [2];
    logic en [2];
    logic ssr [2];
    logic rce [2];
    bit hit;
    en[0] = ena; we[0] = wea; di[0] = dia; ssr[0] = ssra; rce[0] = regcea; old[0] = mem_m[addra];
    en[1] = enb; we[1] = web; di[1] = dib; ssr[1] = ssrb; rce[1] = regceb; old[1] = mem_m[addrb];
    m[0] = lane_mask(wea);
    m[1] = lane_mask(web);
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 2; p++) begin
        if (doreg_c[d][p] && rce[p]) out_m[d][p] = ssr[p] ? srval_c[d][p] : latch_m[d][p];
        if (en[p]) begin
          if (ssr[p] && !doreg_c[d][p]) latch_m[d][p] = srval_c[d][p];
          else if (mode_c[d][p] == 0)    latch_m[d][p] = (old[p] & ~m[p]) | (di[p] & m[p]);
          else if (mode_c[d][p] == 1)    latch_m[d][p] = old[p];
          else if (we[p] == 4'h0)        latch_m[d][p] = old[p];
        end
      end
    hit = ena && enb && (addra == addrb) && (wea != 4'h0 || web != 4'h0);
    coll_m = hit;
    if (hit && cnt_m < 65535) cnt_m++;
    if (enb) mem_m[addrb] = (mem_m[addrb] & ~m[1]) | (dib & m[1]);
    if (ena) mem_m[addra] = (mem_m[addra] & ~m[0]) | (dia & m[0]);
  endtask

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_doa%0d", tag, d), doa[d], exp_do(d, 0));
      chk($sformatf("%s_dob%0d", tag, d), dob[d], exp_do(d, 1));
      chk($sformatf("%s_coll%0d", tag, d), 36'(coll[d]), 36'(coll_m));
      chk($sformatf("%s_cnt%0d", tag, d), 36'(cnt[d]), 36'(cnt_m));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    ena = 1'b0; wea = '0; enb = 1'b0; web = '0;
    ssra = 1'b0; ssrb = 1'b0; regcea = 1'b1; regceb = 1'b1;
  endtask

  typedef struct packed {
    logic        ena;
    logic [3:0]  wea;
    logic [9:0]  addra;
    logic [35:0] dia;
    logic        enb;
    logic [3:0]  web;
    logic [9:0]  addrb;
    logic [35:0] dib;
    logic [35:0] exp_a0;
    logic [35:0] exp_b0;
    logic [35:0] exp_a1;
    logic [35:0] exp_b1;
    logic        exp_coll;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [14];
  string tbl_name [14];

  initial begin
    tbl_name = '{"bw_full", "bw_lane1", "wm_pre", "wm_a", "wm_pre2", "wm_b_read", "wm_b",
                 "wm_b_rd", "coll", "coll_rd", "rd_while_wr", "lane_split", "lane_rd", "diff_addr"};
    tbl[0]  = '{1'b1, 4'hF, 10'd5, 36'h1_2345_6789, 1'b0, 4'h0, 10'd0, 36'h0,
                36'h1_2345_6789, 36'h0, 36'h0, 36'h0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 4'b0010, 10'd5, 36'hF_FFFD_55FF, 1'b0, 4'h0, 10'd0, 36'h0,
                36'h1_2345_5589, 36'h0, 36'h1_2345_6789, 36'h0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 4'hF, 10'd7, 36'h0_0000_0011, 1'b0, 4'h0, 10'd0, 36'h0,
                36'h0_0000_0011, 36'h0, 36'h0, 36'h0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 4'hF, 10'd7, 36'h0_0000_0022, 1'b0, 4'h0, 10'd0, 36'h0,
                36'h0_0000_0022, 36'h0, 36'h0_0000_0011, 36'h0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 4'hF, 10'd7, 36'h0_0000_0011, 1'b0, 4'h0, 10'd0, 36'h0,
                36'h0_0000_0011, 36'h0, 36'h0_0000_0022, 36'h0, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 4'h0, 10'd7, 36'h0, 1'b1, 4'h0, 10'd7, 36'h0,
                36'h0_0000_0011, 36'h0_0000_0011, 36'h0_0000_0022, 36'h0_0000_0011, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 4'h0, 10'd7, 36'h0, 1'b1, 4'hF, 10'd7, 36'h0_0000_0022,
                36'h0_0000_0011, 36'h0_0000_0022, 36'h0_0000_0022, 36'h0_0000_0011, 1'b0, 16'd0};
    tbl[7]  = '{1'b0, 4'h0, 10'd7, 36'h0, 1'b1, 4'h0, 10'd7, 36'h0,
                36'h0_0000_0011, 36'h0_0000_0022, 36'h0_0000_0022, 36'h0_0000_0022, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 4'hF, 10'd9, 36'h1_1111_1111, 1'b1, 4'hF, 10'd9, 36'h2_2222_2222,
                36'h1_1111_1111, 36'h2_2222_2222, 36'h0, 36'h0_0000_0022, 1'b1, 16'd1};
    tbl[9]  = '{1'b1, 4'h0, 10'd9, 36'h0, 1'b1, 4'h0, 10'd9, 36'h0,
                36'h1_1111_1111, 36'h1_1111_1111, 36'h1_1111_1111, 36'h1_1111_1111, 1'b0, 16'd1};
    tbl[10] = '{1'b1, 4'h0, 10'd9, 36'h0, 1'b1, 4'hF, 10'd9, 36'h3_3333_3333,
                36'h1_1111_1111, 36'h3_3333_3333, 36'h1_1111_1111, 36'h1_1111_1111, 1'b1, 16'd2};
    tbl[11] = '{1'b1, 4'b0001, 10'd9, 36'h0, 1'b1, 4'b0011, 10'd9, 36'h0_0003_FFFF,
                36'h3_3333_3200, 36'h3_3333_FFFF, 36'h3_3333_3333, 36'h1_1111_1111, 1'b1, 16'd3};
    tbl[12] = '{1'b1, 4'h0, 10'd9, 36'h0, 1'b1, 4'h0, 10'd9, 36'h0,
                36'h3_3333_FE00, 36'h3_3333_FE00, 36'h3_3333_FE00, 36'h3_3333_FE00, 1'b0, 16'd3};
    tbl[13] = '{1'b1, 4'hF, 10'd10, 36'h0_AAAA_AAAA, 1'b1, 4'hF, 10'd11, 36'h0_5555_5555,
                36'h0_AAAA_AAAA, 36'h0_5555_5555, 36'h0, 36'h3_3333_FE00, 1'b0, 16'd3};

    mode_c  = '{'{0, 0}, '{1, 2}, '{0, 0}};
    doreg_c = '{'{1'b0, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b1}};
    srval_c = '{'{36'h1_5A5A_5A5A, 36'h0_0F0F_0F0F}, '{36'h0_1234_0000, 36'h1_0000_0001},
                '{36'h0_0000_0123, 36'h0_0000_0ABC}};
    for (int i = 0; i < 1024; i++) mem_m[i] = '0;
    model_reset();

    // Reset and default state
    rst = 1'b1;
    set_idle();
    addra = '0; addrb = '0; dia = '0; dib = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_doa2", doa[2], 36'h0);
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_doa%0d", d), doa[d], 36'h0);
      chk($sformatf("rst_dob%0d", d), dob[d], 36'h0);
      chk($sformatf("rst_coll%0d", d), 36'(coll[d]), 36'h0);
      chk($sformatf("rst_cnt%0d", d), 36'(cnt[d]), 36'h0);
    end
    $display("reset: doa0=%h dob0=%h coll=%b cnt=%0d", doa[0], dob[0], coll[0], cnt[0]);

    // Preload the working address range, then settle every read latch to zero
    for (int i = 0; i < 16; i++) begin
      set_idle();
      ena = 1'b1; wea = 4'hF; addra = 10'(i); dia = '0;
      tick();
      $display("preload addr %0d", i);
    end
    set_idle();
    ena = 1'b1; addra = '0; enb = 1'b1; addrb = '0;
    tick();
    check_model("settle");

    // Directed vectors
    for (int r = 0; r < 14; r++) begin
      set_idle();
      ena = tbl[r].ena; wea = tbl[r].wea; addra = tbl[r].addra; dia = tbl[r].dia;
      enb = tbl[r].enb; web = tbl[r].web; addrb = tbl[r].addrb; dib = tbl[r].dib;
      tick();
      chk({tbl_name[r], "_a0"}, doa[0], tbl[r].exp_a0);
      chk({tbl_name[r], "_b0"}, dob[0], tbl[r].exp_b0);
      chk({tbl_name[r], "_a1"}, doa[1], tbl[r].exp_a1);
      chk({tbl_name[r], "_b1"}, dob[1], tbl[r].exp_b1);
      chk({tbl_name[r], "_coll"}, 36'(coll[0]), 36'(tbl[r].exp_coll));
      chk({tbl_name[r], "_cnt"}, 36'(cnt[0]), 36'(tbl[r].exp_cnt));
      $display("vec %s: doa0=%h dob0=%h doa1=%h dob1=%h coll=%b cnt=%0d",
               tbl_name[r], doa[0], dob[0], doa[1], dob[1], coll[0], cnt[0]);
    end

    // Output register on port B of u2: latency, clock enable, set/reset
    set_idle();
    ena = 1'b1; wea = 4'hF; addra = 10'd3; dia = 36'h0_DEAD_BEEF;
    enb = 1'b1; addrb = 10'd4;
    tick();
    set_idle(); tick();
    chk("oreg_pre", dob[2], 36'h0);
    set_idle(); enb = 1'b1; addrb = 10'd3; tick();
    chk("oreg_lat1", dob[2], 36'h0);
    set_idle(); tick();
    chk("oreg_lat2", dob[2], 36'h0_DEAD_BEEF);
    set_idle(); enb = 1'b1; addrb = 10'd4; tick();
    chk("oreg_next", dob[2], 36'h0_DEAD_BEEF);
    set_idle(); regceb = 1'b0; tick();
    chk("oreg_hold", dob[2], 36'h0_DEAD_BEEF);
    set_idle(); tick();
    chk("oreg_release", dob[2], 36'h0);
    set_idle(); enb = 1'b1; addrb = 10'd3; ssrb = 1'b1; tick();
    chk("oreg_ssr", dob[2], 36'h0_0000_0ABC);
    set_idle(); tick();
    chk("oreg_latch_kept", dob[2], 36'h0_DEAD_BEEF);
    $display("oreg: dob2=%h", dob[2]);

    // Asynchronous reset while a registered read is in flight on port A of u2
    set_idle(); ena = 1'b1; wea = 4'hF; addra = 10'd12; dia = 36'h0_CAFE_F00D; tick();
    set_idle(); ena = 1'b1; addra = 10'd12; tick();
    chk("rmr_before", doa[2], 36'h0_CAFE_F00D);
    set_idle(); ena = 1'b1; addra = 10'd12; wea = 4'hF; dia = 36'h0_0BAD_0BAD; tick();
    #3;
    rst = 1'b1;
    #2;
    chk("rmr_async_doa2", doa[2], 36'h0);
    chk("rmr_async_doa0", doa[0], 36'h0);
    chk("rmr_async_dob1", dob[1], 36'h0);
    chk("rmr_async_cnt", 36'(cnt[0]), 36'h0);
    model_reset();
    set_idle();
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    mem_m[12] = 36'h0_0BAD_0BAD;
    set_idle(); ena = 1'b1; addra = 10'd12; tick();
    chk("rmr_lat1", doa[2], 36'h0);
    set_idle(); tick();
    chk("rmr_mem_kept", doa[2], 36'h0_0BAD_0BAD);
    $display("reset mid-read: doa2=%h", doa[2]);

    // Randomised traffic against the reference model
    for (int t = 0; t < 2000; t++) begin
      ena = ($urandom_range(0, 3) != 0);
      wea = 4'($urandom);
      addra = 10'($urandom_range(0, 15));
      dia = 36'({$urandom(), $urandom()});
      ssra = ena && ($urandom_range(0, 15) == 0);
      regcea = ($urandom_range(0, 3) != 0);
      enb = ($urandom_range(0, 3) != 0);
      web = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      addrb = ($urandom_range(0, 3) == 0) ? addra : 10'($urandom_range(0, 15));
      dib = 36'({$urandom(), $urandom()});
      ssrb = enb && ($urandom_range(0, 15) == 0);
      regceb = ($urandom_range(0, 3) != 0);
      tick();
      check_model($sformatf("rnd%0d", t));
      $display("rnd %0d: A en=%b we=%h @%0d B en=%b we=%h @%0d doa0=%h dob0=%h cnt=%0d",
               t, ena, wea, addra, enb, web, addrb, doa[0], dob[0], cnt[0]);
    end

    // Saturate the collision counter
    set_idle();
    ena = 1'b1; wea = 4'hF; addra = 10'd9; dia = 36'h1_1111_1111;
    enb = 1'b1; web = 4'hF; addrb = 10'd9; dib = 36'h2_2222_2222;
    for (int k = 0; k < 70000; k++) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("sat_cnt%0d", d), 36'(cnt[d]), 36'h0_0000_FFFF);
      chk($sformatf("sat_coll%0d", d), 36'(coll[d]), 36'h1);
    end
    $display("saturation burst: cnt=%h coll=%b", cnt[0], coll[0]);
    set_idle(); ena = 1'b1; addra = 10'd9; enb = 1'b1; addrb = 10'd9; tick();
    chk("sat_read_a", doa[0], 36'h1_1111_1111);
    chk("sat_read_b", dob[0], 36'h1_1111_1111);
    chk("sat_coll_drop", 36'(coll[0]), 36'h0);
    chk("sat_cnt_hold", 36'(cnt[0]), 36'h0_0000_FFFF);
    check_model("sat_end");
    $display("post-saturation read: doa0=%h cnt=%h", doa[0], cnt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
